spi_target: RTL
===============

# spi_target

SPI mode-0 target (responder) with an 8-bit register file, the far end of the SPI initiator that drives spi_clk/spi_mosi/spi_cs_n. It oversamples the SPI pins in the system clock domain and decodes command/address/data frames. It exposes the register file to the local core through a host read/write port, plus a pulse per SPI write. It serves as the on-chip peripheral model for loopback and integration benches.

## Interface
- NUM_REGS, 8: register count; power of 2, 2..128; ADDR_W = log2(NUM_REGS).
- ID_BYTE, 8'hA5: byte returned on spi_miso during the command byte.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- spi_clk  in  1  SPI clock from initiator, mode 0 (CPOL=0, CPHA=0).
- spi_cs_n  in  1  active-low chip select.
- spi_mosi  in  1  serial data in, MSB first.
- spi_miso  out  1  serial data out, MSB first.
- spi_miso_oe  out  1  1 while selected (synced cs_n low), else 0.
- host_addr  in  ADDR_W  host read/write address.
- host_we  in  1  host write strobe.
- host_wdata  in  8  host write data.
- host_rdata  out  8  registered read of regs[host_addr], 1-cycle latency.
- spi_wr_pulse  out  1  one-cycle pulse per completed SPI data write.
- spi_wr_addr  out  ADDR_W  address of last SPI write; valid with pulse, held after.

## Operation
- Inputs spi_clk, spi_cs_n, spi_mosi pass through 2-flop synchronizers; edges are detected on the synchronized spi_clk.
- States:
  - ARMED: entered from reset; waits for synced cs_n high, then goes to IDLE.
  - IDLE: cs_n low -> CMD with bit counter 0, shift register loaded with ID_BYTE.
  - CMD: 8 rising edges shift in the command byte.
  - DATA: repeated 8-bit data bytes.
- Command byte: bit7 = 1 write / 0 read; bits[ADDR_W-1:0] = start address; other bits ignored.
- MOSI is sampled on the rising edge. MISO is shifted on the falling edge. The MSB of each new byte is driven immediately when the byte boundary is reached.
- Read frame: at the end of each byte, load regs[addr] into the MISO shift register. Subsequent data bytes on MOSI are ignored.
- Write frame: on the 8th rising edge of each data byte, write regs[addr] and pulse spi_wr_pulse. MISO shifts out the previous value of regs[addr].
- Address advance after each data byte is governed by Configuration.
- cs_n deassert in any state -> IDLE. A partial byte is discarded with no write. spi_miso_oe is 0.
- An SPI write and host_we to the same cycle and address: the SPI write wins and the host write is dropped. Writes to different addresses both complete.
- spi_miso is 0 whenever spi_miso_oe is 0.

## Timing
- Reset values: all regs 0; spi_miso 0; spi_miso_oe 0; host_rdata 0; spi_wr_pulse 0; spi_wr_addr 0; state ARMED.
- Reset mid-frame: the frame is abandoned. The block stays in ARMED until cs_n is seen high, so the remainder of that frame is ignored.
- Synchronizer plus edge-detect latency is 3 clk cycles. clk must be ≥ 8× the spi_clk frequency.
- Each spi_clk high and low phase must be ≥ 4 clk cycles.
- spi_wr_pulse asserts 3–4 clk cycles after the 8th rising spi_clk edge of a data byte.
- spi_cs_n falling edge to first spi_clk rising edge: ≥ 4 clk cycles.
- host_rdata reflects a write (either source) on the cycle after that write.

## Configuration
- SPI_TARGET_AUTOINC_EN:
  - Defined: the address increments after every data byte and wraps modulo NUM_REGS (NUM_REGS-1 -> 0).
  - Undefined: the address is fixed for the whole frame; every data byte reads or writes the same register.

## Test plan
- Reset, host reads addrs 0..7 -> all 0x00. Read frame cmd 0x02 -> MISO 0xA5 during cmd, then 0x00.
- SPI write frame cmd 0x83, data 0x5A -> regs[3] = 0x5A; one spi_wr_pulse with spi_wr_addr = 3; host read addr 3 = 0x5A.
- With AUTOINC_EN: cmd 0x86, data 0x11,0x22,0x33 -> regs[6]=0x11, regs[7]=0x22, regs[0]=0x33; three pulses. Without the macro: regs[6]=0x33 only.
- Host writes 0xC3 to addr 1, then SPI read cmd 0x01 -> MISO second byte 0xC3.
- Abort: write cmd 0x84 + 5 data bits, then cs_n high -> regs[4] unchanged, no pulse. A following frame decodes normally.
- Assert rst_n low mid-frame with cs_n held low: remaining clocks are ignored and no writes occur. After cs_n toggles high/low, a fresh write of 0x77 to addr 2 succeeds.

Source files
------------

// File: rtl/spi_target.sv
// SPI mode-0 target with an 8-bit register file. The pins are oversampled in the clk domain.
// Define SPI_TARGET_AUTOINC_EN to advance the address after every data byte; otherwise the frame address stays fixed.
module spi_target #(
    parameter int         NUM_REGS = 8,
    parameter logic [7:0] ID_BYTE  = 8'hA5,
    localparam int        ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_clk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic              host_we,
    input  logic [7:0]        host_wdata,
    output logic [7:0]        host_rdata,
    output logic              spi_wr_pulse,
    output logic [ADDR_W-1:0] spi_wr_addr
);

    typedef enum logic [1:0] {ARMED, IDLE, CMD, DATA} state_t;

    logic [1:0]        sclk_sync;
    logic [1:0]        cs_sync;
    logic [1:0]        mosi_sync;
    logic              sclk_prev;

    state_t            state;
    logic [2:0]        bit_cnt;
    logic [6:0]        shift_in;
    logic [7:0]        miso_sr;
    logic [ADDR_W-1:0] addr;
    logic              is_write;
    logic [7:0]        regs [NUM_REGS];

    logic              sclk_s;
    logic              cs_n_s;
    logic              mosi_s;
    logic              rise;
    logic              fall;
    logic [7:0]        byte_in;
    logic              byte_done;
    logic              spi_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W-1:0] next_addr;
    logic [7:0]        load_val;

    // The chip-select synchronizer resets to "selected". After a reset, ARMED therefore waits for a real high level on cs_n.
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= 2'b00;
            cs_sync   <= 2'b00;
            mosi_sync <= 2'b00;
            sclk_prev <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], spi_clk};
            cs_sync   <= {cs_sync[0], spi_cs_n};
            mosi_sync <= {mosi_sync[0], spi_mosi};
            sclk_prev <= sclk_sync[1];
        end
    end

    assign sclk_s = sclk_sync[1];
    assign cs_n_s = cs_sync[1];
    assign mosi_s = mosi_sync[1];
    assign rise   = sclk_s & ~sclk_prev;
    assign fall   = ~sclk_s & sclk_prev;

    // NOTE: every signal driven here gets a default first, so no latches are inferred.
    always_comb begin
        byte_in   = {shift_in, mosi_s};
        byte_done = 1'b0;
        spi_we    = 1'b0;
        cmd_addr  = byte_in[ADDR_W-1:0];
        load_val  = '0;
`ifdef SPI_TARGET_AUTOINC_EN
        next_addr = addr + ADDR_W'(1);
`else
        next_addr = addr;
`endif
        if ((state == CMD || state == DATA) && !cs_n_s && rise && bit_cnt == 3'd7)
            byte_done = 1'b1;
        if (byte_done && state == DATA && is_write)
            spi_we = 1'b1;
        if (state == CMD)
            load_val = regs[cmd_addr];
        else if (spi_we && next_addr == addr)
            load_val = byte_in;
        else
            load_val = regs[next_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ARMED;
            bit_cnt      <= 3'd0;
            shift_in     <= 7'd0;
            miso_sr      <= 8'd0;
            addr         <= '0;
            is_write     <= 1'b0;
            spi_miso     <= 1'b0;
            spi_miso_oe  <= 1'b0;
            spi_wr_pulse <= 1'b0;
            spi_wr_addr  <= '0;
        end else begin
            spi_wr_pulse <= 1'b0;
            case (state)
                ARMED: begin
                    if (cs_n_s)
                        state <= IDLE;
                end
                IDLE: begin
                    if (!cs_n_s) begin
                        state       <= CMD;
                        bit_cnt     <= 3'd0;
                        shift_in    <= 7'd0;
                        miso_sr     <= ID_BYTE;
                        spi_miso    <= ID_BYTE[7];
                        spi_miso_oe <= 1'b1;
                    end
                end
                CMD, DATA: begin
                    if (cs_n_s) begin
                        state       <= IDLE;
                        spi_miso    <= 1'b0;
                        spi_miso_oe <= 1'b0;
                    end else begin
                        if (rise) begin
                            shift_in <= byte_in[6:0];
                            bit_cnt  <= bit_cnt + 3'd1;
                        end
                        if (byte_done) begin
                            miso_sr  <= load_val;
                            spi_miso <= load_val[7];
                            if (state == CMD) begin
                                state    <= DATA;
                                is_write <= byte_in[7];
                                addr     <= cmd_addr;
                            end else begin
                                addr <= next_addr;
                                if (spi_we) begin
                                    spi_wr_pulse <= 1'b1;
                                    spi_wr_addr  <= addr;
                                end
                            end
                        end else if (fall && bit_cnt != 3'd0) begin
                            // The fall that follows a byte boundary is skipped, so the freshly loaded MSB stays on the pin.
                            miso_sr  <= {miso_sr[6:0], 1'b0};
                            spi_miso <= miso_sr[6];
                        end
                    end
                end
                default: state <= ARMED;
            endcase
        end
    end

    // NOTE: the register file is reset because its zero state after reset is visible to both ports.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= 8'd0;
            host_rdata <= 8'd0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (spi_we && addr == ADDR_W'(i))
                    regs[i] <= byte_in;
                else if (host_we && host_addr == ADDR_W'(i))
                    regs[i] <= host_wdata;
            end
            host_rdata <= regs[host_addr];
        end
    end

endmodule
